// File: rtl/tx_multilane_pkg.sv
// Shared definitions for the multi-lane serial transmitter.
//   `PAYLOAD_SIZE, `ADDR_BITS : flit field widths; their sum is the default flit width
//   tx_state_e                : framing FSM state encoding
//   frame_beats()             : beats per frame (start + data beats + stop)
//   ptr_width()               : FIFO pointer width, at least one bit
`ifndef TX_MULTILANE_DEFINES
`define TX_MULTILANE_DEFINES
`define PAYLOAD_SIZE 8
`define ADDR_BITS 8
`endif

package tx_multilane_pkg;

    localparam int PAYLOAD_SIZE = `PAYLOAD_SIZE;
    localparam int ADDR_BITS    = `ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_e;

    function automatic int frame_beats(input int data_w, input int lanes);
        return data_w / lanes + 2;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tx_multilane_fifo.sv
// tx_fifo: flit buffer for the transmitter.
//   clk, reset    : clock, synchronous active-high reset
//   push, wdata   : write request and data; ignored while full
//   pop, rdata    : read request; rdata is the current head (valid when !empty)
//   full, empty   : derived from the registered occupancy count
//   count         : number of occupied entries
module tx_fifo
    import tx_multilane_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];
    // full comes from the registered count, so a pop in a full cycle frees room only next cycle.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tx_multilane.sv
// tx_multilane: buffers flits and sends each as a framed burst over LANES serial wires.
//   clk, reset    : clock, synchronous active-high reset
//   req           : push parallel_in into the buffer (refused while tx_busy)
//   parallel_in   : flit to send
//   channel_busy  : downstream not ready; only delays the start of a frame
//   tx_busy       : buffer full
//   serial_out    : frame beats, lane 0 = LSB; zero outside a frame
//   tx_active     : high during every beat of a frame
//   fifo_count    : occupied buffer entries
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a buffered flit and a free channel
// ST_SEND | driving start, data and stop beats
// ST_GAP  | one forced all-zero cycle between consecutive frames
module tx_multilane
    import tx_multilane_pkg::*;
#(
    parameter  int DATA_W     = `PAYLOAD_SIZE + `ADDR_BITS,
    parameter  int LANES      = 1,
    parameter  int FIFO_DEPTH = 2,
    parameter  int ROUTERID   = -1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [DATA_W-1:0] parallel_in,
    input  logic              channel_busy,
    output logic              tx_busy,
    output logic [LANES-1:0]  serial_out,
    output logic              tx_active,
    output logic [CNT_W-1:0]  fifo_count
);

    localparam int BEATS  = frame_beats(DATA_W, LANES);
    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    if (DATA_W % LANES != 0) begin : g_bad_lanes
        $error("tx_multilane: DATA_W must be a multiple of LANES");
    end
    if (FIFO_DEPTH < 1) begin : g_bad_depth
        $error("tx_multilane: FIFO_DEPTH must be at least 1");
    end
    if (ROUTERID < -1) begin : g_bad_id
        $error("tx_multilane: ROUTERID is -1 (unassigned) or a non-negative id");
    end

    tx_state_e          r_state;
    tx_state_e          w_state_nxt;
    logic [BEAT_W-1:0]  r_beat;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  w_head;
    logic               w_pop;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req),
        .pop   (w_pop),
        .wdata (parallel_in),
        .rdata (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (fifo_count)
    );

    assign tx_busy = w_fifo_full;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty && !channel_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: if (r_beat == BEAT_LAST) w_state_nxt = ST_GAP;
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The low lanes of r_shift always hold the current data beat; it shifts
    // after each data beat, not after the start or stop beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat  <= '0;
            r_shift <= '0;
        end else if (w_pop) begin
            r_beat  <= '0;
            r_shift <= w_head;
        end else if (r_state == ST_SEND) begin
            r_beat <= (r_beat == BEAT_LAST) ? '0 : r_beat + 1'b1;
            if (r_beat != '0 && r_beat != BEAT_LAST) r_shift <= r_shift >> LANES;
        end
    end

    assign tx_active = (r_state == ST_SEND);

    always_comb begin
        serial_out = '0;
        if (tx_active) begin
            if (r_beat == '0 || r_beat == BEAT_LAST) serial_out = '1;
            else                                     serial_out = r_shift[LANES-1:0];
        end
    end

endmodule
